// File: rtl/if_fetch_q.sv
// Fetch stage with PC register, 1-cycle synchronous imem interface, and a small
// {pc, instr} queue to decode. Optional misaligned-redirect halt: IF_MISALIGN_CHK_EN.
module if_fetch_q #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter int               QDEPTH   = 2,
    parameter int               PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] fetch_pc,
    output logic            misalign_err
);

    localparam int AW = $clog2(QDEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW:0]     QDEPTH_W = (PW + 1)'(QDEPTH);
    localparam logic [XLEN-1:0] STEP_W   = XLEN'(PC_STEP);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            inflight_q, inflight_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [XLEN-1:0] pc_mem_q [QDEPTH];
    logic [XLEN-1:0] pc_mem_d [QDEPTH];
    logic [XLEN-1:0] instr_mem_q [QDEPTH];
    logic [XLEN-1:0] instr_mem_d [QDEPTH];
    logic            misalign_q, misalign_d;

    logic [PW-1:0] count;
    logic [PW:0]   credit_sum;
    logic          pop;
    logic          push;
    logic          halt;
    logic          issue;

    always_comb begin
        count      = wptr_q - rptr_q;
        pop        = out_valid & out_ready;
        // Entries held plus the one in flight, less the one leaving this cycle.
        credit_sum = {1'b0, count} + {{PW{1'b0}}, inflight_q} - {{PW{1'b0}}, pop};
        halt       = misalign_q;
        issue      = ~rst & ~redirect_valid & ~halt & (credit_sum < QDEPTH_W);
        push       = inflight_q & ~redirect_valid;

        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = fetch_pc_q;
        wptr_d        = wptr_q;
        rptr_d        = rptr_q;
        pc_mem_d      = pc_mem_q;
        instr_mem_d   = instr_mem_q;
        misalign_d    = misalign_q;

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            wptr_d     = '0;
            rptr_d     = '0;
`ifdef IF_MISALIGN_CHK_EN
            misalign_d = |redirect_pc[1:0];
`endif
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + STEP_W;
            end
            if (push) begin
                pc_mem_d[wptr_q[AW-1:0]]    = inflight_pc_q;
                instr_mem_d[wptr_q[AW-1:0]] = imem_rdata;
                wptr_d                      = wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_d = rptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            misalign_q    <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            misalign_q    <= misalign_d;
        end
    end

    // Queue payload needs no reset: outputs are gated by out_valid.
    always_ff @(posedge clk) begin
        pc_mem_q    <= pc_mem_d;
        instr_mem_q <= instr_mem_d;
    end

    assign imem_req     = issue;
    assign imem_addr    = fetch_pc_q;
    assign fetch_pc     = fetch_pc_q;
    assign out_valid    = (wptr_q != rptr_q);
    assign out_pc       = out_valid ? pc_mem_q[rptr_q[AW-1:0]]    : '0;
    assign out_instr    = out_valid ? instr_mem_q[rptr_q[AW-1:0]] : '0;
    assign misalign_err = misalign_q;

endmodule

// File: doc/if_fetch_q.md
Name: if_fetch_q

Overview:
- Parametrised successor to the single-cycle fetch stage, for the pipelined core.
- Owns the PC and drives a synchronous instruction memory with fixed 1-cycle read latency.
- Buffers fetched words in a small FIFO and delivers {pc, instr} to decode over a valid/ready handshake.
- Accepts a single redirect port for jumps, branches and traps; a redirect flushes everything younger.

Parameters:
XLEN, 32, width of PC, addresses and instruction word
RESET_PC, 32'h0000_0000, first fetch address after reset
QDEPTH, 2, fetch queue entries; power of two, >= 2
PC_STEP, 4, sequential PC increment in bytes

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
redirect_valid  in  1  redirect request from execute/commit
redirect_pc  in  XLEN  redirect target
imem_req  out  1  read strobe to instruction memory
imem_addr  out  XLEN  read address, valid when imem_req=1
imem_rdata  in  XLEN  read data, valid exactly one cycle after imem_req
out_valid  out  1  queue head valid to decode
out_ready  in  1  decode accepts head
out_pc  out  XLEN  PC of head entry
out_instr  out  XLEN  instruction of head entry
fetch_pc  out  XLEN  next PC to be requested (debug)
misalign_err  out  1  misaligned redirect flag (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous and active-high, sampled only on the rising edge.
- Reset values:
  - fetch_pc=RESET_PC.
  - Queue empty; out_valid=0; out_pc=0; out_instr=0.
  - In-flight flag=0; imem_req=0; misalign_err=0.
- rst has priority over every other input.
- Request issue:
  - imem_req=1 in a cycle when: not rst, no redirect_valid, and (occupancy + inflight - pop) < QDEPTH, where pop = out_valid & out_ready.
  - imem_addr=fetch_pc, combinational from the register.
  - On issue: fetch_pc <= fetch_pc + PC_STEP, modulo 2^XLEN (wraps to 0).
  - inflight <= 1 with the associated pc captured; otherwise inflight <= 0.
- Response:
  - In the cycle after an issue, if inflight=1 and the response is not killed, {captured pc, imem_rdata} is written at the queue tail.
  - The credit rule above guarantees no overflow.
- Output:
  - out_valid = queue not empty (registered state).
  - A written entry becomes visible to decode the cycle after the response cycle.
  - out_pc/out_instr are held stable while out_valid=1 and out_ready=0.
  - Pop on out_valid & out_ready.
  - Simultaneous write and pop are allowed at any occupancy, including full.
- Steady state: with out_ready=1, throughput is one instruction per cycle.
  - First request goes out in the first cycle after rst deasserts.
  - First out_valid=1 occurs 2 cycles after that request.
- Redirect (cycle T, redirect_valid=1):
  - Queue flushed (occupancy 0); any pop in cycle T is ignored.
  - Response due in T (or T+1) from an earlier request is discarded.
  - No request in T; fetch_pc <= redirect_pc.
  - T+1: imem_req for redirect_pc. T+2: response written. T+3: out_valid=1.
  - Back-to-back redirects: the last one wins; each restarts the T+1 request.
- Redirect arriving while the queue is full or decode is stalled: same flush behaviour, no special case.
- Wrap-around: occupancy counter and pointers are log2(QDEPTH) bits plus one extra bit for full/empty.

Optional Feature:
- Macro: IF_MISALIGN_CHK_EN.
- Defined:
  - Redirect with redirect_pc[1:0] != 0 sets misalign_err=1 (registered, next cycle).
  - Fetch halts: no imem_req, queue stays empty.
  - Halt lasts until the next aligned redirect, which clears misalign_err and resumes per the normal redirect timing.
  - rst clears misalign_err.
- Undefined:
  - misalign_err tied 0.
  - redirect_pc used as-is, with no alignment check.

Test Plan:
1. Reset release, out_ready=1, imem returns addr^32'hA5A5_0000 -> requests at 0x0, 0x4, 0x8 on consecutive cycles; out_valid first high 2 cycles after first req; out_pc 0x0, 0x4, 0x8 with matching instr, one per cycle.
2. out_ready=0 for 6 cycles from steady state -> exactly QDEPTH entries held, imem_req low while full, head stable; release -> in-order drain with no loss or duplication.
3. redirect_valid=1, redirect_pc=0x100 while queue full and a response in flight -> flushed entries never appear; imem_addr=0x100 at T+1; out_pc=0x100 at T+3.
4. Redirects to 0x200 then 0x300 on consecutive cycles -> only 0x300 fetched; no 0x200 output.
5. RESET_PC=32'hFFFF_FFF8 -> out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
6. IF_MISALIGN_CHK_EN defined, redirect to 0x102 -> misalign_err=1, no imem_req; redirect to 0x104 -> misalign_err=0, out_pc=0x104 at T+3.
